keypad_entry_buffer: RTL and testbench

//  Consumer stage for the keypad scanner. Samples the scanner's 4-bit key code and filters it for stability.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/key_stability_filter.sv | 57 +++++
 rtl/keypad_entry_buffer.sv | 183 ++++++++++++++++++
 tb/tb_keypad_entry_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry path: key codes, FSM states and
// the code normalisation used by the stability filter.
package keypad_pkg;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;
   localparam logic [3:0] KEY_NONE = 4'b1101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACK,
      ST_WAIT_REL,
      ST_CONVERT,
      ST_LOAD
   } state_t;

   // Codes 12, 14 and 15 carry no key and are folded onto KEY_NONE
   function automatic logic [3:0] norm_code(input logic [3:0] code);
      return (code > KEY_HASH) ? KEY_NONE : code;
   endfunction

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage

// File: rtl/key_stability_filter.sv
// Two-flop synchronizer followed by an identical-code run counter.
// stable asserts once the same normalised code has been seen STABLE_CYCLES
// times in a row; none_stable asserts after RELEASE_CYCLES of KEY_NONE.
module key_stability_filter
   import keypad_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned RELEASE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] key_code,
   output logic [3:0] stable_code,
   output logic       stable,
   output logic       none_stable
);

   localparam int unsigned CNT_MAX = (STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES : RELEASE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       code_q;
   logic [3:0]       code_n;
   logic [CNT_W-1:0] run_cnt;

   assign code_n = norm_code(sync2);

   // Synchronizer; idles at KEY_NONE so reset never looks like digit 0
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= KEY_NONE;
         sync2 <= KEY_NONE;
      end else begin
         sync1 <= key_code;
         sync2 <= sync1;
      end
   end

   // Run-length counter of identical codes, restarting at 1 on any change
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         code_q  <= KEY_NONE;
         run_cnt <= '0;
      end else if (code_n != code_q) begin
         code_q  <= code_n;
         run_cnt <= CNT_W'(1);
      end else if (run_cnt != CNT_W'(CNT_MAX)) begin
         run_cnt <= run_cnt + 1'b1;
      end
   end

   assign stable_code = code_q;
   assign stable      = (run_cnt >= CNT_W'(STABLE_CYCLES));
   assign none_stable = (code_q == KEY_NONE) && (run_cnt >= CNT_W'(RELEASE_CYCLES));

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad consumer: filters scanner codes, acknowledges accepted keys, keeps
// a BCD entry buffer with backspace, and on commit converts it to binary
// for a valid/ready consumer.
// Optional inactivity clear: define KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_entry_buffer
   import keypad_pkg::*;
#(
   parameter int unsigned MAX_DIGITS     = 6,
   parameter int unsigned VALUE_W        = 20,
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned RELEASE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [3:0]              key_code,
   output logic [31:0]             ack_key,
   output logic [VALUE_W-1:0]      entry_value,
   output logic                    entry_valid,
   input  logic                    entry_ready,
   output logic [2:0]              digit_count,
   output logic [4*MAX_DIGITS-1:0] bcd_digits,
   output logic                    entry_err,
   output logic                    timeout_pulse
);

   localparam int unsigned BCD_W   = 4 * MAX_DIGITS;
   localparam logic [2:0]  MAX_CNT = 3'(MAX_DIGITS);

   state_t             state;
   logic               ack_q;
   logic [3:0]         key_q;
   logic [VALUE_W-1:0] acc;
   logic [VALUE_W-1:0] acc_next;
   logic [2:0]         idx;
   logic [BCD_W-1:0]   bcd_shifted;
   logic [3:0]         conv_digit;
   logic [3:0]         stable_code;
   logic               stable;
   logic               none_stable;
   logic               hash_blocked;
   logic               go;
   logic               tmo_hit;

   key_stability_filter #(
      .STABLE_CYCLES  (STABLE_CYCLES),
      .RELEASE_CYCLES (RELEASE_CYCLES)
   ) u_filter (
      .clock       (clock),
      .reset_n     (reset_n),
      .key_code    (key_code),
      .stable_code (stable_code),
      .stable      (stable),
      .none_stable (none_stable)
   );

   // A commit is held off while the previous value is still unread
   assign hash_blocked = (stable_code == KEY_HASH) && (digit_count != 3'd0) && entry_valid;
   assign go           = (state == ST_IDLE) && stable && (stable_code != KEY_NONE) && !hash_blocked;

   // Converter walks from the oldest digit (index count-1) down to 0
   assign bcd_shifted = bcd_digits >> {idx, 2'b00};
   assign conv_digit  = bcd_shifted[3:0];
   assign acc_next    = (acc << 3) + (acc << 1) + VALUE_W'(conv_digit);

   assign ack_key = {31'b0, ack_q};

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
   logic [31:0] tmo_cnt;
   logic        tmo_run;

   assign tmo_run = (digit_count != 3'd0) && ((state == ST_IDLE) || (state == ST_WAIT_REL));
   assign tmo_hit = tmo_run && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Inactivity counter; restarts on every ack and whenever nothing is buffered
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt <= '0;
      end else if (ack_q || !tmo_run || tmo_hit) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 32'd1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Control FSM with buffer, converter and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         ack_q         <= 1'b0;
         key_q         <= '0;
         acc           <= '0;
         idx           <= '0;
         entry_value   <= '0;
         entry_valid   <= 1'b0;
         digit_count   <= '0;
         bcd_digits    <= '0;
         entry_err     <= 1'b0;
         timeout_pulse <= 1'b0;
      end else begin
         ack_q         <= 1'b0;
         entry_err     <= 1'b0;
         timeout_pulse <= 1'b0;

         if (entry_valid && entry_ready) begin
            entry_valid <= 1'b0;
         end

         // tmo_hit is only possible in IDLE/WAIT_REL, which never touch the buffer
         if (tmo_hit) begin
            bcd_digits    <= '0;
            digit_count   <= '0;
            timeout_pulse <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (go && !tmo_hit) begin
                  ack_q <= 1'b1;
                  key_q <= stable_code;
                  state <= ST_ACK;
               end
            end

            ST_ACK: begin
               state <= ST_WAIT_REL;
               if (is_digit(key_q)) begin
                  if (digit_count == MAX_CNT) begin
                     entry_err <= 1'b1;
                  end else begin
                     bcd_digits  <= {bcd_digits[BCD_W-5:0], key_q};
                     digit_count <= digit_count + 3'd1;
                  end
               end else if (key_q == KEY_STAR) begin
                  if (digit_count == 3'd0) begin
                     entry_err <= 1'b1;
                  end else begin
                     bcd_digits  <= {4'h0, bcd_digits[BCD_W-1:4]};
                     digit_count <= digit_count - 3'd1;
                  end
               end else if (key_q == KEY_HASH) begin
                  if (digit_count == 3'd0) begin
                     entry_err <= 1'b1;
                  end else begin
                     acc   <= '0;
                     idx   <= digit_count - 3'd1;
                     state <= ST_CONVERT;
                  end
               end
            end

            ST_WAIT_REL: begin
               if (none_stable) begin
                  state <= ST_IDLE;
               end
            end

            ST_CONVERT: begin
               acc <= acc_next;
               if (idx == 3'd0) begin
                  state <= ST_LOAD;
               end else begin
                  idx <= idx - 3'd1;
               end
            end

            ST_LOAD: begin
               entry_value <= acc;
               entry_valid <= 1'b1;
               bcd_digits  <= '0;
               digit_count <= '0;
               state       <= ST_WAIT_REL;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Self-checking bench for keypad_entry_buffer: directed scenarios plus a
// randomized key stream checked against a queue-based entry model.
module tb_keypad_entry_buffer;

   localparam int MAXD = 6;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic [3:0]  key_code;
   logic [31:0] ack_key;
   logic [19:0] entry_value;
   logic        entry_valid;
   logic        entry_ready;
   logic [2:0]  digit_count;
   logic [23:0] bcd_digits;
   logic        entry_err;
   logic        timeout_pulse;

   keypad_entry_buffer #(
      .MAX_DIGITS     (MAXD),
      .VALUE_W        (20),
      .STABLE_CYCLES  (4),
      .RELEASE_CYCLES (4),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .key_code      (key_code),
      .ack_key       (ack_key),
      .entry_value   (entry_value),
      .entry_valid   (entry_valid),
      .entry_ready   (entry_ready),
      .digit_count   (digit_count),
      .bcd_digits    (bcd_digits),
      .entry_err     (entry_err),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // observed event counters
   int ack_cnt = 0, err_cnt = 0, tmo_cnt = 0, cyc = 0;
   int last_ack_cyc = 0, valid_rise_cyc = 0;
   logic prev_ack = 1'b0, prev_valid = 1'b0;
   int got_q[$];

   // reference model
   int mq[$];
   int exp_commits[$];
   int exp_acks = 0, exp_errs = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   always @(negedge clock) begin
      cyc++;
      if (ack_key[0] === 1'b1) begin
         ack_cnt++;
         last_ack_cyc = cyc;
         check_val("ack_single_cycle", {31'b0, prev_ack}, 32'd0);
      end
      prev_ack = ack_key[0];
      if (entry_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = entry_valid;
      if (entry_err === 1'b1) err_cnt++;
      if (timeout_pulse === 1'b1) tmo_cnt++;
      if (entry_valid && entry_ready) got_q.push_back(int'(entry_value));
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic press(input logic [3:0] code, input int hold, input int gap);
      key_code = code;
      tick(hold);
      key_code = 4'd13;
      tick(gap);
   endtask

   function automatic logic [23:0] model_bcd();
      logic [23:0] b = '0;
      foreach (mq[i]) b = (b << 4) | 24'(mq[i]);
      return b;
   endfunction

   task automatic model_apply(input int code);
      int v;
      exp_acks++;
      if (code <= 9) begin
         if (mq.size() == MAXD) exp_errs++;
         else mq.push_back(code);
      end else if (code == 10) begin
         if (mq.size() == 0) exp_errs++;
         else void'(mq.pop_back());
      end else if (code == 11) begin
         if (mq.size() == 0) exp_errs++;
         else begin
            v = 0;
            foreach (mq[i]) v = v * 10 + mq[i];
            exp_commits.push_back(v);
            mq.delete();
         end
      end
   endtask

   task automatic check_state(input string tag);
      check_val({tag, "_count"}, 32'(digit_count), 32'(mq.size()));
      check_val({tag, "_bcd"}, 32'(bcd_digits), 32'(model_bcd()));
      check_val({tag, "_acks"}, ack_cnt, exp_acks);
      check_val({tag, "_errs"}, err_cnt, exp_errs);
      check_val({tag, "_ack_hi"}, {1'b0, ack_key[31:1]}, 32'd0);
   endtask

   task automatic key(input int code);
      press(4'(code), $urandom_range(8, 14), $urandom_range(14, 20));
      model_apply(code);
      check_state($sformatf("key%0d", code));
   endtask

   initial begin
      int a0, waited, r, code;
      reset_n     = 1'b0;
      key_code    = 4'd13;
      entry_ready = 1'b0;
      tick(3);
      check_val("rst_ack", ack_key, 32'd0);
      check_val("rst_value", 32'(entry_value), 32'd0);
      check_val("rst_valid", 32'(entry_valid), 32'd0);
      check_val("rst_count", 32'(digit_count), 32'd0);
      check_val("rst_bcd", 32'(bcd_digits), 32'd0);
      reset_n = 1'b1;
      tick(5);

      // 1: 1,2,3,# with consumer stalled; value held until ready
      key(1); key(2); key(3); key(11);
      check_val("t1_valid", 32'(entry_valid), 32'd1);
      check_val("t1_value", 32'(entry_value), 32'd123);
      check_val("t1_latency", valid_rise_cyc - last_ack_cyc, 32'd5);
      tick(10);
      check_val("t1_hold_valid", 32'(entry_valid), 32'd1);
      entry_ready = 1'b1;
      tick(1);
      entry_ready = 1'b0;
      tick(1);
      check_val("t1_drop_valid", 32'(entry_valid), 32'd0);
      check_val("t1_retain_value", 32'(entry_value), 32'd123);

      // 2: backspace
      entry_ready = 1'b1;
      key(4); key(5); key(10); key(6); key(11);
      check_val("t2_value", 32'(entry_value), 32'd46);

      // 3: overflow on the seventh digit
      for (int i = 0; i < 7; i++) key(9);
      key(11);
      check_val("t3_value", 32'(entry_value), 32'd999999);

      // 4: commit back-pressure
      entry_ready = 1'b0;
      key(7); key(11);
      check_val("t4_valid7", 32'(entry_valid), 32'd1);
      check_val("t4_value7", 32'(entry_value), 32'd7);
      key(8);
      a0 = ack_cnt;
      key_code = 4'd11;
      tick(30);
      check_val("t4_hash_blocked", ack_cnt - a0, 32'd0);
      check_val("t4_still7", 32'(entry_value), 32'd7);
      entry_ready = 1'b1;
      tick(1);
      entry_ready = 1'b0;
      tick(20);
      check_val("t4_hash_acked", ack_cnt - a0, 32'd1);
      key_code = 4'd13;
      tick(20);
      model_apply(11);
      check_state("t4_after");
      check_val("t4_value8", 32'(entry_value), 32'd8);
      check_val("t4_valid8", 32'(entry_valid), 32'd1);
      entry_ready = 1'b1;
      tick(2);

      // 5: short glitch is ignored
      a0 = ack_cnt;
      press(4'd5, 3, 15);
      check_val("t5_glitch_noack", ack_cnt - a0, 32'd0);
      check_state("t5_glitch");

      // 5b: async reset in the middle of a conversion
      key(1); key(2); key(3); key(4); key(5);
      a0 = ack_cnt;
      key_code = 4'd11;
      waited = 0;
      while (ack_cnt == a0 && waited < 40) begin
         tick(1);
         waited++;
      end
      check_val("t5_hash_ack_seen", 32'(ack_cnt != a0), 32'd1);
      reset_n = 1'b0;
      #1;
      check_val("t5_rst_ack", ack_key, 32'd0);
      check_val("t5_rst_value", 32'(entry_value), 32'd0);
      check_val("t5_rst_valid", 32'(entry_valid), 32'd0);
      check_val("t5_rst_count", 32'(digit_count), 32'd0);
      check_val("t5_rst_bcd", 32'(bcd_digits), 32'd0);
      check_val("t5_rst_err", 32'(entry_err), 32'd0);
      check_val("t5_rst_tmo", 32'(timeout_pulse), 32'd0);
      exp_acks++;
      mq.delete();
      key_code = 4'd13;
      tick(3);
      reset_n = 1'b1;
      tick(8);
      check_state("t5_post_rst");

      // randomized key stream against the model
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      key($urandom_range(0, 9));
         else if (r < 70) key(10);
         else if (r < 82) key(11);
         else if (TMO_ON) key($urandom_range(0, 9));
         else if (r < 90) begin
            code = $urandom_range(12, 15);
            if (code == 13) code = 14;
            press(4'(code), $urandom_range(8, 14), $urandom_range(14, 20));
            check_state("rnd_junk");
         end else begin
            press(4'($urandom_range(0, 9)), 3, $urandom_range(10, 16));
            check_state("rnd_glitch");
         end
      end

      // 6: inactivity behaviour
      a0 = tmo_cnt;
      key(3);
      tick(150);
      if (TMO_ON) begin
         mq.delete();
         check_val("t6_tmo_pulses", tmo_cnt - a0, 32'd1);
      end else begin
         check_val("t6_tmo_pulses", tmo_cnt - a0, 32'd0);
      end
      check_state("t6_after_idle");

      // all transferred commits in order
      check_val("commit_count", got_q.size(), exp_commits.size());
      for (int i = 0; i < got_q.size() && i < exp_commits.size(); i++)
         check_val($sformatf("commit%0d", i), got_q[i], exp_commits[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
